// File: rtl/hx8352_init_seq_if.sv
// Write bus between the HX8352 init sequencer (master) and the panel bus writer (slave).
interface hx8352_init_seq_if;
    logic       wr_req;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ack;

    modport master (output wr_req, output wr_rs, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_rs, input wr_data, output wr_ack);
endinterface

// File: rtl/hx8352_init_seq.sv
// Walks an init ROM of CMD/DATA/DELAY/END words, issuing panel bus writes and
// millisecond delays, then latches init_done until reset.
module hx8352_init_seq #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DONE_SYNC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [15:0]           rom_data,
    hx8352_init_seq_if.master     bus,
    output logic                  delay_step,
    output logic [7:0]            delay_ms,
    input  logic                  delay_done,
    output logic                  busy,
    output logic                  init_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WRITE,
        DLY_ARM,
        DLY_WAIT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic                 wr_req_q, wr_req_d;
    logic                 wr_rs_q, wr_rs_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic                 delay_step_q, delay_step_d;
    logic [7:0]           delay_ms_q, delay_ms_d;
    logic                 busy_q, busy_d;
    logic                 init_done_q, init_done_d;
    logic                 start_q, start_d;
    logic [DONE_SYNC-1:0] sync_q, sync_d;
    logic [3:0]           arm_cnt_q, arm_cnt_d;

    logic done_s;
    logic advance;
    logic finish;
    logic unused_rom_bits;

    assign done_s          = sync_q[DONE_SYNC-1];
    assign unused_rom_bits = ^rom_data[13:8];

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        wr_req_d     = wr_req_q;
        wr_rs_d      = wr_rs_q;
        wr_data_d    = wr_data_q;
        delay_step_d = 1'b0;
        delay_ms_d   = delay_ms_q;
        busy_d       = busy_q;
        init_done_d  = init_done_q;
        start_d      = start;
        arm_cnt_d    = arm_cnt_q;
        advance      = 1'b0;
        finish       = 1'b0;

        sync_d[0] = delay_done;
        for (int unsigned i = 1; i < DONE_SYNC; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    state_d    = FETCH;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                case (rom_data[15:14])
                    2'b00, 2'b01: begin
                        state_d   = WRITE;
                        wr_req_d  = 1'b1;
                        wr_rs_d   = rom_data[14];
                        wr_data_d = rom_data[7:0];
                    end
                    2'b10: begin
                        state_d      = DLY_ARM;
                        delay_ms_d   = rom_data[7:0];
                        delay_step_d = 1'b1;
                        arm_cnt_d    = '0;
                    end
                    default: finish = 1'b1;
                endcase
            end
            WRITE: begin
                if (bus.wr_ack) begin
                    wr_req_d = 1'b0;
                    advance  = 1'b1;
                end
            end
            DLY_ARM: begin
                // A step that never pulls done low within 16 cycles is assumed lost.
                if (!done_s) begin
                    state_d = DLY_WAIT;
                end else if (arm_cnt_q == 4'd15) begin
                    delay_step_d = 1'b1;
                    arm_cnt_d    = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 4'd1;
                end
            end
            DLY_WAIT: begin
                if (done_s) advance = 1'b1;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        // The top ROM word is executed but never followed by a wrap to 0.
        if (advance) begin
            if (rom_addr_q == '1) begin
                finish = 1'b1;
            end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = FETCH;
            end
        end

        if (finish) begin
            state_d      = DONE;
            busy_d       = 1'b0;
            init_done_d  = 1'b1;
            wr_req_d     = 1'b0;
            wr_rs_d      = 1'b0;
            wr_data_d    = '0;
            delay_step_d = 1'b0;
            delay_ms_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rom_addr_q   <= '0;
            wr_req_q     <= 1'b0;
            wr_rs_q      <= 1'b0;
            wr_data_q    <= '0;
            delay_step_q <= 1'b0;
            delay_ms_q   <= '0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            start_q      <= 1'b0;
            sync_q       <= '1;
            arm_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            wr_req_q     <= wr_req_d;
            wr_rs_q      <= wr_rs_d;
            wr_data_q    <= wr_data_d;
            delay_step_q <= delay_step_d;
            delay_ms_q   <= delay_ms_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            start_q      <= start_d;
            sync_q       <= sync_d;
            arm_cnt_q    <= arm_cnt_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign bus.wr_req  = wr_req_q;
    assign bus.wr_rs   = wr_rs_q;
    assign bus.wr_data = wr_data_q;
    assign delay_step  = delay_step_q;
    assign delay_ms    = delay_ms_q;
    assign busy        = busy_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Scoreboard bench for hx8352_init_seq: ROM, bus writer and ms delay unit are
// behavioural; expected writes and delay steps are queued and popped by monitors.
module tb_hx8352_init_seq;

    localparam int MS_CYC = 10;

    typedef struct {
        int         unit;
        int         kind;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   step_cyc[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ack_delay = 1;
    int   ignore_steps = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        delay_step;
    logic [7:0]  delay_ms;
    logic        delay_done;
    logic        busy, init_done;
    logic [1:0]  rom_addr2;
    logic [15:0] rom_data2 = '0;
    logic        delay_step2;
    logic [7:0]  delay_ms2;
    logic        busy2, init_done2;
    logic [15:0] rom [256];

    hx8352_init_seq_if bus ();
    hx8352_init_seq_if bus2 ();

    hx8352_init_seq #(.ADDR_W(8), .DONE_SYNC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .bus(bus), .delay_step(delay_step), .delay_ms(delay_ms), .delay_done(delay_done),
        .busy(busy), .init_done(init_done)
    );

    hx8352_init_seq #(.ADDR_W(2), .DONE_SYNC(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .bus(bus2), .delay_step(delay_step2), .delay_ms(delay_ms2), .delay_done(1'b1),
        .busy(busy2), .init_done(init_done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_data  <= rom[rom_addr];
    always @(posedge clk) rom_data2 <= {8'h00, 8'hA0 + {6'd0, rom_addr2}};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void sb_pop(int unit, int kind, logic rs, logic [7:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: unit %0d kind %0d rs %0b data %02h, expected nothing", unit, kind, rs, d);
            return;
        end
        e = exp_q.pop_front();
        check("sb_event", {8'(unit), 8'(kind), 7'd0, rs, d}, {8'(e.unit), 8'(e.kind), 7'd0, e.rs, e.data});
    endfunction

    function automatic void push_wr(int unit, logic rs, logic [7:0] d);
        exp_t e;
        e.unit = unit; e.kind = 0; e.rs = rs; e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_dly(logic [7:0] ms);
        exp_t e;
        e.unit = 0; e.kind = 1; e.rs = 1'b0; e.data = ms;
        exp_q.push_back(e);
    endfunction

    // Monitors: accepted writes, delay steps, and write/step exclusivity.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_req && bus.wr_ack) sb_pop(0, 0, bus.wr_rs, bus.wr_data);
            if (delay_step) begin
                sb_pop(0, 1, 1'b0, delay_ms);
                step_cyc.push_back(cyc);
            end
            if (bus.wr_req || delay_step) check("req_step_excl", 32'(bus.wr_req & delay_step), 0);
            if (bus2.wr_req && bus2.wr_ack) sb_pop(1, 0, bus2.wr_rs, bus2.wr_data);
        end
    end

    initial begin : ack0
        int cnt;
        cnt = 0;
        bus.wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus.wr_ack = 1'b0; cnt = 0;
            end else if (bus.wr_ack) begin
                bus.wr_ack = 1'b0;
            end else if (bus.wr_req) begin
                if (cnt >= ack_delay) begin bus.wr_ack = 1'b1; cnt = 0; end
                else cnt++;
            end
        end
    end

    initial begin : ack2
        int cnt;
        cnt = 0;
        bus2.wr_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                bus2.wr_ack = 1'b0; cnt = 0;
            end else if (bus2.wr_ack) begin
                bus2.wr_ack = 1'b0;
            end else if (bus2.wr_req) begin
                if (cnt >= ack_delay) begin bus2.wr_ack = 1'b1; cnt = 0; end
                else cnt++;
            end
        end
    end

    // Millisecond delay unit: done low for delay_ms*MS_CYC cycles after an accepted step.
    initial begin : dly
        int ms;
        bit stable;
        bit rst_hit;
        delay_done = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst_n && delay_step) begin
                if (ignore_steps > 0) begin
                    ignore_steps--;
                end else begin
                    ms = int'(delay_ms);
                    stable = 1'b1;
                    rst_hit = 1'b0;
                    delay_done = 1'b0;
                    for (int i = 0; i < ((ms == 0) ? 1 : ms * MS_CYC); i++) begin
                        @(posedge clk); #1;
                        if (!rst_n) rst_hit = 1'b1;
                        if (!rst_hit && delay_ms != 8'(ms)) stable = 1'b0;
                    end
                    delay_done = 1'b1;
                    if (!rst_hit) check("delay_ms_held", 32'(stable), 1);
                end
            end
        end
    end

    task automatic load_end();
        for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {3'd0, rom_addr, bus.wr_req, bus.wr_rs, bus.wr_data, delay_step, delay_ms, busy, init_done}, 0);
        check("reset_outputs2", 32'({rom_addr2, bus2.wr_req, bus2.wr_rs, bus2.wr_data, busy2, init_done2}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        step_cyc.delete();
    endtask

    task automatic pulse_start(input int unit);
        @(negedge clk);
        if (unit == 0) start = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int unit, input int budget, output int dc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (unit == 0) ? init_done : init_done2;
        end
        dc = cyc;
        check("done_timeout", 32'(seen), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int  dc;
        bit  seen;
        bit  stable;
        bit  quiet;
        logic [16:0] cap;

        // Two writes with prompt acks.
        load_end();
        do_reset();
        rom[0] = 16'h0028;
        rom[1] = 16'h4001;
        push_wr(0, 1'b0, 8'h28);
        push_wr(0, 1'b1, 8'h01);
        ack_delay = 1;
        pulse_start(0);
        wait_done(0, 200, dc);
        check("t1_status", 32'({busy, init_done}), 1);
        check("t1_addr", 32'(rom_addr), 2);
        check("t1_sb_empty", 32'(exp_q.size()), 0);

        // Single 5 ms delay.
        load_end();
        do_reset();
        rom[0] = 16'h8005;
        push_dly(8'd5);
        pulse_start(0);
        wait_done(0, 500, dc);
        check("t2_sb_empty", 32'(exp_q.size()), 0);
        check("t2_step_count", 32'(step_cyc.size()), 1);
        check("t2_latency_ok", 32'((step_cyc.size() > 0) ? ((dc - step_cyc[0]) >= 5 * MS_CYC) : 0), 1);
        check("t2_idle_outputs", 32'({delay_ms, delay_step, bus.wr_req, busy}), 0);

        // Ack withheld 10 cycles; a start edge while busy is ignored.
        load_end();
        do_reset();
        rom[0] = 16'h002C;
        rom[1] = 16'h4055;
        push_wr(0, 1'b0, 8'h2C);
        push_wr(0, 1'b1, 8'h55);
        ack_delay = 10;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.wr_req;
        end
        check("t3_req_seen", 32'(seen), 1);
        cap = {rom_addr, bus.wr_rs, bus.wr_data};
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.wr_req || {rom_addr, bus.wr_rs, bus.wr_data} != cap) stable = 1'b0;
            if (i == 2) start = 1'b1;
            if (i == 4) start = 1'b0;
        end
        check("t3_stable", 32'(stable), 1);
        check("t3_captured", 32'(cap), 32'({8'h00, 1'b0, 8'h2C}));
        wait_done(0, 200, dc);
        check("t3_sb_empty", 32'(exp_q.size()), 0);
        ack_delay = 1;

        // First delay step is lost; a re-pulse 16 cycles later completes it.
        load_end();
        do_reset();
        rom[0] = 16'h8002;
        push_dly(8'd2);
        push_dly(8'd2);
        ignore_steps = 1;
        pulse_start(0);
        wait_done(0, 400, dc);
        check("t4_sb_empty", 32'(exp_q.size()), 0);
        check("t4_steps", 32'(step_cyc.size()), 2);
        check("t4_repulse_gap", 32'((step_cyc.size() == 2) ? (step_cyc[1] - step_cyc[0]) : 0), 16);

        // Reset during DLY_WAIT, quiet afterwards, then a clean rerun.
        load_end();
        do_reset();
        rom[0] = 16'h8014;
        push_dly(8'd20);
        pulse_start(0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = !delay_done;
        end
        check("t5_delay_started", 32'(seen), 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_reset_outputs", {3'd0, rom_addr, bus.wr_req, bus.wr_rs, bus.wr_data, delay_step, delay_ms, busy, init_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.wr_req || delay_step || busy || init_done || rom_addr != 8'd0) quiet = 1'b0;
        end
        check("t5_quiet", 32'(quiet), 1);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = delay_done;
        end
        check("t5_unit_idle", 32'(seen), 1);
        check("t5_sb_empty_before", 32'(exp_q.size()), 0);
        rom[0] = 16'h8003;
        push_dly(8'd3);
        pulse_start(0);
        wait_done(0, 300, dc);
        check("t5_rerun_status", 32'({busy, init_done}), 1);
        check("t5_sb_empty", 32'(exp_q.size()), 0);

        // ADDR_W=2, four CMD words and no END: execute all four, stop at address 3.
        do_reset();
        for (int i = 0; i < 4; i++) push_wr(1, 1'b0, 8'hA0 + 8'(i));
        pulse_start(1);
        wait_done(1, 200, dc);
        check("t6_addr", 32'(rom_addr2), 3);
        check("t6_busy", 32'(busy2), 0);
        repeat (10) @(negedge clk);
        check("t6_no_wrap", 32'({rom_addr2, init_done2, delay_step2, delay_ms2}), 32'({2'd3, 1'b1, 1'b0, 8'd0}));
        check("t6_sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hx8352_init_seq.md
HX8352_INIT_SEQ -- requirements
Module: hx8352_init_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: init ROM address width.
REQ-002 SHALL have parameter DONE_SYNC, default 2: synchronizer stages on delay_done.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: rising edge requests a sequence run.
REQ-006 SHALL have port rom_addr, output, ADDR_W: init ROM read address.
REQ-007 SHALL have port rom_data, input, 16: ROM word, valid one cycle after rom_addr; [15:14] type (00 CMD, 01 DATA, 10 DELAY, 11 END), [7:0] payload.
REQ-008 SHALL have port wr_req, output, 1: bus write request to the HX8352 bus writer.
REQ-009 SHALL have port wr_rs, output, 1: register select, 0 = command, 1 = data.
REQ-010 SHALL have port wr_data, output, 8: write payload.
REQ-011 SHALL have port wr_ack, input, 1: the writer accepts the write.
REQ-012 SHALL have port delay_step, output, 1: one-cycle start pulse to the ms delay unit.
REQ-013 SHALL have port delay_ms, output, 8: delay length in ms, held stable from the step pulse until done.
REQ-014 SHALL have port delay_done, input, 1: delay unit done; high at idle and low while counting.
REQ-015 SHALL have port busy, output, 1: a sequence is in progress.
REQ-016 SHALL have port init_done, output, 1: the sequence completed; sticky until reset.

Function
REQ-017 SHALL implement the states IDLE, FETCH, DECODE, WRITE, DLY_ARM, DLY_WAIT and DONE.
REQ-018 In IDLE, a start rising edge (start high, previous-cycle start low) SHALL cause entry to FETCH with rom_addr=0 and busy=1 on the next cycle.
REQ-019 FETCH SHALL last exactly one cycle (ROM latency) and then go to DECODE.
REQ-020 DECODE SHALL dispatch on rom_data[15:14]:
- CMD: go to WRITE with wr_rs=0 and wr_data=rom_data[7:0].
- DATA: go to WRITE with wr_rs=1 and wr_data=rom_data[7:0].
- DELAY: go to DLY_ARM with delay_ms=rom_data[7:0] and delay_step=1 for that single cycle.
- END: go to DONE.
REQ-021 In WRITE, wr_req, wr_rs and wr_data SHALL stay stable until wr_ack is sampled high.
REQ-022 On a wr_ack cycle, wr_req SHALL drop on the next edge and rom_addr SHALL increment, returning to FETCH.
REQ-023 wr_ack SHALL be ignored outside WRITE.
REQ-024 delay_done SHALL pass through a DONE_SYNC-flop synchronizer whose flops reset to 1; the FSM uses only the synchronized value.
REQ-025 DLY_ARM SHALL wait for synchronized done=0, then go to DLY_WAIT.
REQ-026 DLY_WAIT SHALL wait for synchronized done=1, then increment rom_addr and go to FETCH.
REQ-027 delay_ms=0 SHALL be handled identically to any other value, with no shortcut.
REQ-028 If DLY_ARM does not see done=0 within 16 cycles, the FSM SHALL treat the step as lost, re-pulse delay_step and restart the 16-cycle window.
REQ-029 On entry to DONE: busy=0, init_done=1, and all bus and delay outputs idle.
REQ-030 DONE SHALL be terminal and ignore start until reset.
REQ-031 If rom_addr reaches 2^ADDR_W-1 and that word is not END, the FSM SHALL execute the word and then go to DONE; the address SHALL never wrap to 0.
REQ-032 A start edge while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-033 wr_req and delay_step SHALL never be high in the same cycle.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and the following outputs: rom_addr=0, wr_req=0, wr_rs=0, wr_data=0, delay_step=0, delay_ms=0, busy=0, init_done=0.
REQ-035 rst_n low SHALL also set the start edge register to 0 and the done synchronizer flops to 1.
REQ-036 Reset asserted mid-WRITE or mid-delay SHALL abandon the operation; after release, no output activity SHALL occur until a new start edge.
REQ-037 A start held high across reset release SHALL count as a rising edge on the first post-reset cycle.

Verification
REQ-038 The bench SHALL cover: ROM {CMD 0x28, DATA 0x01, END}, wr_ack one cycle after wr_req -> two writes (rs=0/0x28, then rs=1/0x01), then busy=0 and init_done=1.
REQ-039 The bench SHALL cover: ROM {DELAY 5, END} with a behavioural ms unit (done low 5 ms after step) -> exactly one delay_step pulse, delay_ms=5 held throughout, DONE reached at least 5 ms after the step.
REQ-040 The bench SHALL cover: wr_ack withheld 10 cycles -> wr_req, wr_rs and wr_data stable all 10 cycles, and rom_addr unchanged.
REQ-041 The bench SHALL cover: delay unit ignores the first step -> delay_step re-pulsed after 16 cycles, and the sequence completes.
REQ-042 The bench SHALL cover: rst_n low during DLY_WAIT -> all outputs at reset values; no activity until a new start; a rerun then completes normally.
REQ-043 The bench SHALL cover: ADDR_W=2 with ROM of four CMD words and no END -> four writes, then DONE with rom_addr=3 and no wrap.
